wb_stage: RTL and testbench

Write-back stage that sits directly upstream of the register file's single write port. It accepts results from the ALU (single-cycle producer) and the load unit (variable-latency producer) via valid/ready handshakes. It serialises them into one registered write per cycle (RD/WData/RegWr) and buffers up to two load results. It also forwards not-yet-written values to operand fetch so reads of in-flight registers return current data.

---
 rtl/wb_stage.sv | 181 ++++++++++++++++++
 tb/tb_wb_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: register-file write-back stage.
// Merges ALU results (single-cycle) and load results (variable latency) into
// one registered write per cycle. Up to two load results are held in a small
// FIFO. Values that are buffered or waiting on the output register are
// forwarded to operand fetch so reads of those registers see current data.

module wb_stage (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        AluValid,
  input  logic [4:0]  AluRd,
  input  logic [31:0] AluData,
  output logic        AluReady,
  input  logic        LdValid,
  input  logic [4:0]  LdRd,
  input  logic [31:0] LdData,
  output logic        LdReady,
  output logic [4:0]  RD,
  output logic [31:0] WData,
  output logic        RegWr,
  input  logic [4:0]  QRs1,
  input  logic [4:0]  QRs2,
  output logic        FwdHit1,
  output logic        FwdHit2,
  output logic [31:0] FwdData1,
  output logic [31:0] FwdData2,
  output logic        Idle
);

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } fwd_t;

  // Load FIFO storage and bookkeeping
  logic [4:0]  fifo_rd   [2];
  logic [31:0] fifo_data [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;

  // Derived FIFO views
  logic        head_valid;
  logic        second_valid;
  logic        young_idx;
  logic        conflict;

  // Arbitration results
  logic        push;
  logic        pop;
  logic        sel_any;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  fwd_t        fwd1;
  fwd_t        fwd2;

  assign head_valid   = (count != 2'd0);
  assign second_valid = (count == 2'd2);
  // The youngest entry sits just behind the tail: the head when only one
  // entry is held, the other slot when both are held.
  assign young_idx    = second_valid ? ~head : head;

  // WAW guard: an ALU result must not overtake a buffered load to the same reg
  assign conflict = (AluRd != 5'd0) &&
                    ((head_valid   && (fifo_rd[head]  == AluRd)) ||
                     (second_valid && (fifo_rd[~head] == AluRd)));

  assign LdReady  = (count != 2'd2);
  assign AluReady = (count != 2'd2) && !conflict;
  assign push     = LdValid && LdReady && (LdRd != 5'd0);

  // Pick the source for this cycle's write: full FIFO first, then ALU, then FIFO
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    pop      = 1'b0;
    sel_any  = 1'b0;
    sel_rd   = 5'd0;
    sel_data = 32'd0;
    if (count == 2'd2) begin
      pop      = 1'b1;
      sel_any  = 1'b1;
      sel_rd   = fifo_rd[head];
      sel_data = fifo_data[head];
    end else if (AluValid && !conflict) begin
      sel_any  = 1'b1;
      sel_rd   = AluRd;
      sel_data = AluData;
    end else if (count != 2'd0) begin
      pop      = 1'b1;
      sel_any  = 1'b1;
      sel_rd   = fifo_rd[head];
      sel_data = fifo_data[head];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!Reset_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO payload write
  always_ff @(posedge Clk) begin
    // NOTE: the payload array is deliberately not reset; every reader is gated
    // by count, so stale contents are never observed.
    if (push) begin
      fifo_rd[tail]   <= LdRd;
      fifo_data[tail] <= LdData;
    end
  end

  // Registered write port towards the register file
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RD    <= 5'd0;
      WData <= 32'd0;
      RegWr <= 1'b0;
    end else if (sel_any) begin
      RD    <= sel_rd;
      WData <= sel_data;
      RegWr <= (sel_rd != 5'd0);
    end else begin
      RegWr <= 1'b0;
    end
  end

  // Youngest FIFO entry, then older FIFO entry, then the output register
  function automatic fwd_t lookup(
    input logic [4:0]  q,
    input logic        y_valid,
    input logic [4:0]  y_rd,
    input logic [31:0] y_data,
    input logic        o_valid,
    input logic [4:0]  o_rd,
    input logic [31:0] o_data,
    input logic        w_valid,
    input logic [4:0]  w_rd,
    input logic [31:0] w_data
  );
    fwd_t r;
    r = '0;
    if (q != 5'd0) begin
      if (y_valid && (y_rd == q))      r = '{hit: 1'b1, data: y_data};
      else if (o_valid && (o_rd == q)) r = '{hit: 1'b1, data: o_data};
      else if (w_valid && (w_rd == q)) r = '{hit: 1'b1, data: w_data};
    end
    return r;
  endfunction

  // Forwarding lookups, one per operand-fetch query port
  always_comb begin
    fwd1 = lookup(QRs1, head_valid, fifo_rd[young_idx], fifo_data[young_idx],
                  second_valid, fifo_rd[head], fifo_data[head],
                  RegWr, RD, WData);
    fwd2 = lookup(QRs2, head_valid, fifo_rd[young_idx], fifo_data[young_idx],
                  second_valid, fifo_rd[head], fifo_data[head],
                  RegWr, RD, WData);
  end

  assign FwdHit1  = fwd1.hit;
  assign FwdData1 = fwd1.data;
  assign FwdHit2  = fwd2.hit;
  assign FwdData2 = fwd2.data;
  assign Idle     = (count == 2'd0) && !RegWr;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed stimulus for wb_stage with a write scoreboard.
// Stimulus pushes each expected register-file write into a queue; a monitor
// on the falling edge pops and compares whenever RegWr is high. Handshake,
// forwarding and idle outputs are checked directly after inputs settle.

module tb_wb_stage;

  logic        Clk;
  logic        Reset_n;
  logic        AluValid;
  logic [4:0]  AluRd;
  logic [31:0] AluData;
  logic        AluReady;
  logic        LdValid;
  logic [4:0]  LdRd;
  logic [31:0] LdData;
  logic        LdReady;
  logic [4:0]  RD;
  logic [31:0] WData;
  logic        RegWr;
  logic [4:0]  QRs1;
  logic [4:0]  QRs2;
  logic        FwdHit1;
  logic        FwdHit2;
  logic [31:0] FwdData1;
  logic [31:0] FwdData2;
  logic        Idle;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  wb_stage dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .AluValid (AluValid),
    .AluRd    (AluRd),
    .AluData  (AluData),
    .AluReady (AluReady),
    .LdValid  (LdValid),
    .LdRd     (LdRd),
    .LdData   (LdData),
    .LdReady  (LdReady),
    .RD       (RD),
    .WData    (WData),
    .RegWr    (RegWr),
    .QRs1     (QRs1),
    .QRs2     (QRs2),
    .FwdHit1  (FwdHit1),
    .FwdHit2  (FwdHit2),
    .FwdData1 (FwdData1),
    .FwdData2 (FwdData2),
    .Idle     (Idle)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back('{rd: rd, data: data});
  endtask

  // Drive both producer ports, then let combinational outputs settle
  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    AluValid = av;
    AluRd    = ard;
    AluData  = ad;
    LdValid  = lv;
    LdRd     = lrd;
    LdData   = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard monitor: every observed write must match the oldest expectation
  always @(negedge Clk) begin
    if (Reset_n && RegWr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write at %0t",
                 RD, WData, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (RD !== e.rd || WData !== e.data) begin
          errors++;
          $display("FAIL write_order: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h at %0t",
                   RD, WData, e.rd, e.data, $time);
        end
      end
    end
  end

  initial begin
    Reset_n = 1'b0;
    QRs1    = 5'd5;
    QRs2    = 5'd0;
    set_in(0, 0, 0, 0, 0, 0);

    // Reset state
    check("rst_regwr",    RegWr,    0);
    check("rst_rd",       RD,       0);
    check("rst_wdata",    WData,    0);
    check("rst_ldready",  LdReady,  1);
    check("rst_aluready", AluReady, 1);
    check("rst_fwdhit1",  FwdHit1,  0);
    check("rst_idle",     Idle,     1);
    #12 Reset_n = 1'b1;
    tick();

    // ALU only: one write per cycle, one cycle after acceptance
    set_in(1, 5, 32'h11, 0, 0, 0);
    check("alu5_ready", AluReady, 1);
    expect_wr(5, 32'h11);
    tick();
    check("alu5_regwr", RegWr, 1);
    check("alu5_rd", RD, 5);
    set_in(1, 6, 32'h22, 0, 0, 0);
    check("alu6_ready", AluReady, 1);
    expect_wr(6, 32'h22);
    tick();
    check("alu6_wdata", WData, 32'h22);
    set_in(1, 7, 32'h33, 0, 0, 0);
    check("alu7_ready", AluReady, 1);
    expect_wr(7, 32'h33);
    tick();
    check("alu7_regwr", RegWr, 1);
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    check("alu_done_idle", Idle, 1);

    // Load buffering and priority
    set_in(1, 10, 32'h100, 1, 8, 32'hA0);
    check("b1_aluready", AluReady, 1);
    check("b1_ldready", LdReady, 1);
    expect_wr(10, 32'h100);
    tick();
    set_in(1, 10, 32'h101, 1, 9, 32'hB0);
    check("b2_aluready", AluReady, 1);
    check("b2_ldready", LdReady, 1);
    expect_wr(10, 32'h101);
    tick();
    set_in(1, 10, 32'h102, 0, 0, 0);
    check("b3_full_ldready", LdReady, 0);
    check("b3_full_aluready", AluReady, 0);
    expect_wr(8, 32'hA0);
    tick();
    check("b3_pop_rd", RD, 8);
    // FIFO back to one entry (Rd 9): the held ALU result wins this cycle
    check("b4_aluready", AluReady, 1);
    expect_wr(10, 32'h102);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    expect_wr(9, 32'hB0);
    tick();
    set_in(1, 10, 32'h103, 0, 0, 0);
    check("b6_aluready", AluReady, 1);
    expect_wr(10, 32'h103);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    tick();

    // WAW guard: ALU Rd 3 waits until the buffered load to Rd 3 is written
    set_in(1, 11, 32'h111, 1, 1, 32'hC1);
    expect_wr(11, 32'h111);
    tick();
    set_in(1, 12, 32'h112, 1, 3, 32'hC3);
    check("c2_aluready", AluReady, 1);
    expect_wr(12, 32'h112);
    tick();
    QRs1 = 5'd3;
    set_in(1, 3, 32'hA3, 0, 0, 0);
    check("c3_aluready_full", AluReady, 0);
    check("c3_fwd_hit", FwdHit1, 1);
    check("c3_fwd_data", FwdData1, 32'hC3);
    expect_wr(1, 32'hC1);
    tick();
    check("c4_aluready_conflict", AluReady, 0);
    check("c4_ldready", LdReady, 1);
    expect_wr(3, 32'hC3);
    tick();
    check("c5_aluready", AluReady, 1);
    expect_wr(3, 32'hA3);
    tick();
    check("c5_fwd_out_data", FwdData1, 32'hA3);
    set_in(0, 0, 0, 0, 0, 0);
    tick();

    // Forwarding priority
    QRs1 = 5'd4;
    QRs2 = 5'd0;
    set_in(1, 4, 32'h0, 1, 4, 32'h1);
    check("d1_aluready", AluReady, 1);
    expect_wr(4, 32'h0);
    tick();
    check("d2_fifo_over_out_hit", FwdHit1, 1);
    check("d2_fifo_over_out_data", FwdData1, 32'h1);
    QRs2 = 5'd13;
    set_in(1, 13, 32'h113, 1, 4, 32'h2);
    check("d2_aluready", AluReady, 1);
    expect_wr(13, 32'h113);
    tick();
    QRs2 = 5'd0;
    set_in(0, 0, 0, 0, 0, 0);
    check("d3_young_hit", FwdHit1, 1);
    check("d3_young_data", FwdData1, 32'h2);
    check("d3_q0_hit", FwdHit2, 0);
    check("d3_q0_data", FwdData2, 0);
    QRs2 = 5'd13;
    #1;
    check("d3_out_hit", FwdHit2, 1);
    check("d3_out_data", FwdData2, 32'h113);
    expect_wr(4, 32'h1);
    tick();
    check("d4_fifo_over_out_data", FwdData1, 32'h2);
    expect_wr(4, 32'h2);
    tick();
    check("d5_out_only_hit", FwdHit1, 1);
    check("d5_out_only_data", FwdData1, 32'h2);
    tick();
    check("d6_no_hit", FwdHit1, 0);
    check("d6_no_data", FwdData1, 0);
    check("d6_idle", Idle, 1);

    // x0 handling: both producers target register 0 with one load buffered
    QRs1 = 5'd0;
    QRs2 = 5'd0;
    set_in(1, 14, 32'h114, 1, 15, 32'h115);
    expect_wr(14, 32'h114);
    tick();
    set_in(1, 0, 32'h55, 1, 0, 32'h66);
    check("e1_aluready", AluReady, 1);
    check("e1_ldready", LdReady, 1);
    check("e1_q0_hit", FwdHit1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    check("e1_regwr", RegWr, 0);
    check("e1_not_idle", Idle, 0);
    check("e1_ldready_after", LdReady, 1);
    expect_wr(15, 32'h115);
    tick();
    check("e2_not_idle", Idle, 0);
    tick();
    check("e3_idle", Idle, 1);

    // Asynchronous reset with a full FIFO
    QRs1 = 5'd17;
    set_in(1, 16, 32'h116, 1, 17, 32'h117);
    expect_wr(16, 32'h116);
    tick();
    set_in(1, 18, 32'h118, 1, 19, 32'h119);
    expect_wr(18, 32'h118);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    check("f_full_ldready", LdReady, 0);
    check("f_fwd17_hit", FwdHit1, 1);
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("f_rst_regwr", RegWr, 0);
    check("f_rst_rd", RD, 0);
    check("f_rst_wdata", WData, 0);
    check("f_rst_idle", Idle, 1);
    check("f_rst_ldready", LdReady, 1);
    check("f_rst_aluready", AluReady, 1);
    check("f_rst_fwd17", FwdHit1, 0);
    @(posedge Clk);
    @(posedge Clk);
    #3 Reset_n = 1'b1;
    tick();
    tick();
    tick();
    check("f_post_regwr", RegWr, 0);
    check("f_post_idle", Idle, 1);

    // Recovery after reset
    set_in(1, 20, 32'h120, 0, 0, 0);
    expect_wr(20, 32'h120);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
